// File: rtl/fir_sample_feeder.sv
// rtl/fir_sample_feeder.sv - input sample FIFO and frame sequencer feeding a FIR controller
module fir_sample_feeder #(
    parameter int DATAWIDHT  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDHT-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 go,
    input  logic [LEN_W-1:0]     frame_len,
    output logic                 start,
    output logic                 stop,
    input  logic                 ld_reg,
    input  logic                 done,
    output logic [DATAWIDHT-1:0] x_out,
    output logic                 busy,
    output logic                 underrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_START,
        S_RUN,
        S_WAIT
    } state_t;

    state_t state, next_state;

    logic [DATAWIDHT-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wptr, rptr;
    logic [CNT_W-1:0]     count;
    logic [LEN_W-1:0]     remaining;

    logic fifo_empty;
    logic push;
    logic pop;
    logic accept_go;
    logic consume;

    assign fifo_empty = (count == '0);
    assign in_ready   = (count != FULL_CNT);
    assign push       = in_valid && in_ready;
    // A consume is a controller strobe in RUN; it only moves the FIFO when there is data.
    assign consume    = (state == S_RUN) && ld_reg;
    assign pop        = consume && !fifo_empty;
    assign accept_go  = (state == S_IDLE) && go && (frame_len != '0);
    assign x_out      = fifo_empty ? '0 : mem[rptr];
    assign busy       = (state != S_IDLE);

    // Sample storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and start/stop decode.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        stop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept_go) begin
                    next_state = S_FILL;
                end
            end
            S_FILL: begin
                if (!fifo_empty) begin
                    next_state = S_START;
                end
            end
            S_START: begin
                start      = 1'b1;
                next_state = S_RUN;
            end
            S_RUN: begin
                if (ld_reg && (remaining == LEN_W'(1))) begin
                    stop       = 1'b1;
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Frame sample countdown and sticky underrun, both re-armed by an accepted go.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            underrun  <= 1'b0;
        end else if (accept_go) begin
            remaining <= frame_len;
            underrun  <= 1'b0;
        end else if (consume) begin
            remaining <= remaining - LEN_W'(1);
            if (fifo_empty) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule
